// File: rtl/collision_detect_if.sv
// rtl/collision_detect_if.sv - Compute_collide/Break handshake between ball tracker and collision processor
interface collision_detect_if;
   logic        Compute_collide;
   logic        Break;
   logic [31:0] ball_velocity;
   logic [16:0] ball_angle;
   logic [31:0] new_ball_velocity;
   logic [16:0] new_ball_angle;

   modport master (
      output Compute_collide, ball_velocity, ball_angle,
      input  Break, new_ball_velocity, new_ball_angle
   );

   modport slave (
      input  Compute_collide, ball_velocity, ball_angle,
      output Break, new_ball_velocity, new_ball_angle
   );
endinterface

// File: rtl/collision_detect.sv
// rtl/collision_detect.sv - ball motion tracker and collision request initiator
module collision_detect #(
   parameter int POS_W       = 10,
   parameter int FIELD_W     = 640,
   parameter int FIELD_H     = 480,
   parameter int X_INIT      = 320,
   parameter int Y_INIT      = 240,
   parameter int HIT_R       = 8,
   parameter int ACK_TIMEOUT = 16,
   parameter int COOLDOWN    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       init_velocity,
   input  logic [16:0]       init_angle,
   input  logic              step,
   input  logic [POS_W-1:0]  paddle_x,
   input  logic [POS_W-1:0]  paddle_y,
   collision_detect_if.master cif,
   output logic [POS_W-1:0]  ball_x,
   output logic [POS_W-1:0]  ball_y,
   output logic              ball_stopped,
   output logic              out_of_bounds,
   output logic              ack_err
);

   localparam int SW = POS_W + 2;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic signed [SW-1:0] X_MAX    = SW'(FIELD_W - 1);
   localparam logic signed [SW-1:0] Y_MAX    = SW'(FIELD_H - 1);
   localparam logic [TW-1:0]        TMO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0]        COOL_LD  = CW'(COOLDOWN);
   localparam logic [POS_W:0]       HIT_LIM  = (POS_W+1)'(HIT_R);

   typedef enum logic [2:0] {IDLE, MOVE, CHECK, REQ, STOPPED} state_t;

   state_t           state_q, state_d;
   logic [POS_W-1:0] x_q, x_d, y_q, y_d;
   logic [31:0]      vel_q, vel_d;
   logic [16:0]      ang_q, ang_d;
   logic             oob_q, oob_d, aerr_q, aerr_d;
   logic [CW-1:0]    cool_q, cool_d;
   logic [TW-1:0]    tmo_q, tmo_d;

   logic signed [SW-1:0] mag_x, mag_y, nx, ny;
   logic signed [POS_W:0] dx, dy;
   logic [POS_W:0]       adx, ady;
   logic                 hit;

   // Both sign-magnitude components zero: the ball has nowhere to go.
   function automatic logic is_still(input logic [31:0] v);
      return (v[30:16] == 15'd0) && (v[14:0] == 15'd0);
   endfunction

   always_comb begin
      mag_x = $signed({2'b00, vel_q[16 +: POS_W]});
      mag_y = $signed({2'b00, vel_q[0 +: POS_W]});
      nx    = $signed({2'b00, x_q}) + (vel_q[31] ? -mag_x : mag_x);
      ny    = $signed({2'b00, y_q}) + (vel_q[15] ? -mag_y : mag_y);
      dx    = $signed({1'b0, x_q}) - $signed({1'b0, paddle_x});
      dy    = $signed({1'b0, y_q}) - $signed({1'b0, paddle_y});
      adx   = dx[POS_W] ? $unsigned(-dx) : $unsigned(dx);
      ady   = dy[POS_W] ? $unsigned(-dy) : $unsigned(dy);
      hit   = (adx <= HIT_LIM) && (ady <= HIT_LIM);
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      vel_d   = vel_q;
      ang_d   = ang_q;
      oob_d   = oob_q;
      aerr_d  = aerr_q;
      cool_d  = cool_q;
      tmo_d   = tmo_q;
      if (start) begin
         x_d     = POS_W'(X_INIT);
         y_d     = POS_W'(Y_INIT);
         vel_d   = init_velocity;
         ang_d   = init_angle;
         oob_d   = 1'b0;
         aerr_d  = 1'b0;
         cool_d  = '0;
         tmo_d   = '0;
         state_d = is_still(init_velocity) ? STOPPED : MOVE;
      end else begin
         case (state_q)
            MOVE: if (step) begin
               if (ny[SW-1]) begin
                  y_d       = '0;
                  vel_d[15] = ~vel_q[15];
               end else if (ny > Y_MAX) begin
                  y_d       = Y_MAX[POS_W-1:0];
                  vel_d[15] = ~vel_q[15];
               end else begin
                  y_d = ny[POS_W-1:0];
               end
               if (nx[SW-1] || nx > X_MAX) begin
                  x_d     = nx[SW-1] ? '0 : X_MAX[POS_W-1:0];
                  oob_d   = 1'b1;
                  state_d = STOPPED;
               end else begin
                  x_d = nx[POS_W-1:0];
                  if (cool_q != '0) cool_d = cool_q - 1'b1;
                  else              state_d = CHECK;
               end
            end
            CHECK: begin
               tmo_d   = '0;
               state_d = hit ? REQ : MOVE;
            end
            // Steps landing here are dropped; position waits for the handshake.
            REQ: begin
               if (cif.Break) begin
                  vel_d   = cif.new_ball_velocity;
                  ang_d   = cif.new_ball_angle;
                  cool_d  = COOL_LD;
                  tmo_d   = '0;
                  state_d = is_still(cif.new_ball_velocity) ? STOPPED : MOVE;
               end else if (tmo_q == TMO_LAST) begin
                  aerr_d  = 1'b1;
                  cool_d  = COOL_LD;
                  tmo_d   = '0;
                  state_d = MOVE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            IDLE, STOPPED: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= POS_W'(X_INIT);
         y_q     <= POS_W'(Y_INIT);
         vel_q   <= '0;
         ang_q   <= '0;
         oob_q   <= 1'b0;
         aerr_q  <= 1'b0;
         cool_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vel_q   <= vel_d;
         ang_q   <= ang_d;
         oob_q   <= oob_d;
         aerr_q  <= aerr_d;
         cool_q  <= cool_d;
         tmo_q   <= tmo_d;
      end
   end

   assign cif.Compute_collide = (state_q == REQ);
   assign cif.ball_velocity   = vel_q;
   assign cif.ball_angle      = ang_q;
   assign ball_x              = x_q;
   assign ball_y              = y_q;
   assign ball_stopped        = (state_q == STOPPED);
   assign out_of_bounds       = oob_q;
   assign ack_err             = aerr_q;

endmodule

// File: tb/tb_collision_detect.sv
// tb/tb_collision_detect.sv - self-checking bench for collision_detect against a field-level ball model
module tb_collision_detect;
   logic        clk = 1'b0;
   logic        rst_n, start, step;
   logic [31:0] init_velocity;
   logic [16:0] init_angle;
   logic [9:0]  paddle_x, paddle_y, ball_x, ball_y;
   logic        ball_stopped, out_of_bounds, ack_err;
   int          n_pass = 0;
   int          n_total = 0;

   collision_detect_if cif();

   collision_detect dut (
      .clk(clk), .rst_n(rst_n), .start(start), .init_velocity(init_velocity),
      .init_angle(init_angle), .step(step), .paddle_x(paddle_x), .paddle_y(paddle_y),
      .cif(cif), .ball_x(ball_x), .ball_y(ball_y), .ball_stopped(ball_stopped),
      .out_of_bounds(out_of_bounds), .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_MOVE = 1, M_STOP = 2;
   int          m_x, m_y, m_mx, m_my, m_cool, m_mode;
   bit          m_sx, m_sy, m_oob, m_aerr;
   logic [16:0] m_ang;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [31:0] m_vel();
      return {m_sx, 15'(m_mx), m_sy, 15'(m_my)};
   endfunction

   function automatic logic [31:0] rand_vel();
      if ($urandom_range(0, 4) == 0) return 32'h0;
      return {1'($urandom_range(0, 1)), 15'($urandom_range(0, 12)),
              1'($urandom_range(0, 1)), 15'($urandom_range(0, 12))};
   endfunction

   task automatic model_reset();
      m_x = 320; m_y = 240; m_mx = 0; m_my = 0; m_sx = 0; m_sy = 0;
      m_cool = 0; m_mode = M_IDLE; m_oob = 0; m_aerr = 0; m_ang = '0;
   endtask

   task automatic model_start(input logic [31:0] v, input logic [16:0] a);
      m_x = 320; m_y = 240;
      m_sx = v[31]; m_mx = int'(v[30:16]); m_sy = v[15]; m_my = int'(v[14:0]);
      m_ang = a; m_oob = 0; m_aerr = 0; m_cool = 0;
      m_mode = (m_mx == 0 && m_my == 0) ? M_STOP : M_MOVE;
   endtask

   task automatic model_step(output bit hit);
      int nx, ny;
      hit = 0;
      if (m_mode != M_MOVE) return;
      ny = m_y + (m_sy ? -m_my : m_my);
      if (ny < 0)        begin m_y = 0;   m_sy = !m_sy; end
      else if (ny > 479) begin m_y = 479; m_sy = !m_sy; end
      else m_y = ny;
      nx = m_x + (m_sx ? -m_mx : m_mx);
      if (nx < 0 || nx > 639) begin
         m_x = (nx < 0) ? 0 : 639; m_oob = 1; m_mode = M_STOP;
      end else begin
         m_x = nx;
         if (m_cool > 0) m_cool--;
         else hit = (iabs(m_x - int'(paddle_x)) <= 8) && (iabs(m_y - int'(paddle_y)) <= 8);
      end
   endtask

   task automatic model_break(input int d, input logic [31:0] nv, input logic [16:0] na);
      m_cool = 4;
      if (d < 16) begin
         m_sx = nv[31]; m_mx = int'(nv[30:16]); m_sy = nv[15]; m_my = int'(nv[14:0]);
         m_ang = na;
         m_mode = (m_mx == 0 && m_my == 0) ? M_STOP : M_MOVE;
      end else begin
         m_aerr = 1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; start = 0; step = 0; cif.Break = 0;
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   task automatic do_start(input logic [31:0] v, input logic [16:0] a);
      @(negedge clk);
      init_velocity = v; init_angle = a; start = 1;
      @(negedge clk);
      start = 0;
      model_start(v, a);
   endtask

   task automatic do_step(input bit noise, output bit hit);
      model_step(hit);
      @(negedge clk);
      step = 1; cif.Break = noise;
      @(negedge clk);
      step = 0; cif.Break = 0;
      @(negedge clk);
   endtask

   task automatic do_break(input int d, input logic [31:0] nv, input logic [16:0] na);
      cif.new_ball_velocity = nv;
      cif.new_ball_angle = na;
      if (d < 16) begin
         repeat (d) @(negedge clk);
         cif.Break = 1;
         @(negedge clk);
         cif.Break = 0;
      end else begin
         repeat (16) @(negedge clk);
      end
      model_break(d, nv, na);
   endtask

   task automatic test_reset();
      bit h;
      rst_n = 0; start = 0; step = 0; paddle_x = 0; paddle_y = 0;
      init_velocity = 0; init_angle = 0;
      cif.Break = 0; cif.new_ball_velocity = 0; cif.new_ball_angle = 0;
      repeat (2) @(negedge clk);
      model_reset();
      n_total++; if (ball_x !== 10'd320 || ball_y !== 10'd240) $display("FAIL reset_pos: got (%0d,%0d) want (320,240)", ball_x, ball_y); else n_pass++;
      n_total++; if ({cif.Compute_collide, ball_stopped, out_of_bounds, ack_err} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {cif.Compute_collide, ball_stopped, out_of_bounds, ack_err}); else n_pass++;
      n_total++; if (cif.ball_velocity !== 32'h0 || cif.ball_angle !== 17'h0) $display("FAIL reset_vel: got %h/%h want 0/0", cif.ball_velocity, cif.ball_angle); else n_pass++;
      rst_n = 1;
      do_step(1, h);
      n_total++; if (ball_x !== 10'd320 || ball_y !== 10'd240 || cif.Compute_collide !== 1'b0) $display("FAIL idle_step: got (%0d,%0d) req %b want (320,240) req 0", ball_x, ball_y, cif.Compute_collide); else n_pass++;
   endtask

   task automatic test_motion();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0004_0003, 17'h1_2345);
      for (int i = 0; i < 3; i++) begin
         do_step(0, h);
         n_total++; if (cif.Compute_collide !== 1'b0) $display("FAIL motion_req%0d: got %b want 0", i, cif.Compute_collide); else n_pass++;
      end
      n_total++; if (ball_x !== 10'd332 || ball_y !== 10'd249) $display("FAIL motion_pos: got (%0d,%0d) want (332,249)", ball_x, ball_y); else n_pass++;
      n_total++; if (cif.ball_velocity !== 32'h0004_0003 || cif.ball_angle !== 17'h1_2345) $display("FAIL motion_vel: got %h/%h want 00040003/12345", cif.ball_velocity, cif.ball_angle); else n_pass++;
   endtask

   task automatic test_wall();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0000_8007, 17'h0);
      repeat (34) do_step(0, h);
      n_total++; if (ball_y !== 10'd2 || ball_x !== 10'd320) $display("FAIL wall_pre: got (%0d,%0d) want (320,2)", ball_x, ball_y); else n_pass++;
      do_step(0, h);
      n_total++; if (ball_y !== 10'd0 || cif.ball_velocity[15:0] !== 16'h0007) $display("FAIL wall_reflect: got y=%0d vy=%h want y=0 vy=0007", ball_y, cif.ball_velocity[15:0]); else n_pass++;
      do_step(0, h);
      n_total++; if (ball_y !== 10'd7) $display("FAIL wall_after: got %0d want 7", ball_y); else n_pass++;
   endtask

   task automatic test_collision();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0008_0006, 17'h0_1111);
      paddle_x = 330; paddle_y = 245;
      do_step(0, h);
      n_total++; if (ball_x !== 10'd328 || ball_y !== 10'd246 || cif.Compute_collide !== 1'b1) $display("FAIL hit_req: got (%0d,%0d) req %b want (328,246) req 1", ball_x, ball_y, cif.Compute_collide); else n_pass++;
      do_break(1, 32'h8004_0003, 17'h0_0abc);
      n_total++; if (cif.Compute_collide !== 1'b0) $display("FAIL hit_drop: got %b want 0", cif.Compute_collide); else n_pass++;
      n_total++; if (cif.ball_velocity !== 32'h8004_0003 || cif.ball_angle !== 17'h0_0abc) $display("FAIL hit_latch: got %h/%h want 80040003/00abc", cif.ball_velocity, cif.ball_angle); else n_pass++;
      @(negedge clk);
      n_total++; if (cif.Compute_collide !== 1'b0) $display("FAIL hit_norearm: got %b want 0", cif.Compute_collide); else n_pass++;
      do_step(0, h);
      n_total++; if (ball_x !== 10'd324 || ball_y !== 10'd249 || cif.Compute_collide !== 1'b0) $display("FAIL hit_next: got (%0d,%0d) req %b want (324,249) req 0", ball_x, ball_y, cif.Compute_collide); else n_pass++;
   endtask

   task automatic test_stop();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0008_0006, 17'h0);
      paddle_x = 330; paddle_y = 245;
      do_step(0, h);
      do_break(0, 32'h0, 17'h1_0001);
      n_total++; if (ball_stopped !== 1'b1 || cif.Compute_collide !== 1'b0) $display("FAIL stop_state: got stopped %b req %b want 1 0", ball_stopped, cif.Compute_collide); else n_pass++;
      repeat (3) do_step(0, h);
      n_total++; if (ball_x !== 10'd328 || ball_y !== 10'd246 || ball_stopped !== 1'b1) $display("FAIL stop_frozen: got (%0d,%0d) stopped %b want (328,246) 1", ball_x, ball_y, ball_stopped); else n_pass++;
   endtask

   task automatic test_timeout();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0008_0006, 17'h0_0777);
      paddle_x = 330; paddle_y = 245;
      do_step(0, h);
      n_total++; if (cif.Compute_collide !== 1'b1) $display("FAIL tmo_req: got %b want 1", cif.Compute_collide); else n_pass++;
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         n_total++; if (cif.Compute_collide !== 1'b1) $display("FAIL tmo_hold%0d: got %b want 1", k, cif.Compute_collide); else n_pass++;
      end
      @(negedge clk);
      model_break(16, 32'h0, 17'h0);
      n_total++; if (cif.Compute_collide !== 1'b0 || ack_err !== 1'b1) $display("FAIL tmo_drop: got req %b err %b want 0 1", cif.Compute_collide, ack_err); else n_pass++;
      n_total++; if (cif.ball_velocity !== 32'h0008_0006 || cif.ball_angle !== 17'h0_0777) $display("FAIL tmo_vel: got %h/%h want 00080006/00777", cif.ball_velocity, cif.ball_angle); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         paddle_x = 10'(m_x + 8); paddle_y = 10'(m_y + 6);
         do_step(0, h);
         n_total++; if (cif.Compute_collide !== (i == 4)) $display("FAIL tmo_cool%0d: got %b want %b", i, cif.Compute_collide, i == 4); else n_pass++;
      end
      n_total++; if (ack_err !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", ack_err); else n_pass++;
   endtask

   task automatic test_out_of_bounds();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0006_0000, 17'h0);
      repeat (53) do_step(0, h);
      n_total++; if (ball_x !== 10'd638) $display("FAIL oob_pre: got %0d want 638", ball_x); else n_pass++;
      do_step(0, h);
      n_total++; if (ball_x !== 10'd639 || out_of_bounds !== 1'b1 || ball_stopped !== 1'b1) $display("FAIL oob_hit: got x=%0d oob %b stop %b want 639 1 1", ball_x, out_of_bounds, ball_stopped); else n_pass++;
      do_step(0, h);
      n_total++; if (ball_x !== 10'd639 || ball_y !== 10'd240) $display("FAIL oob_frozen: got (%0d,%0d) want (639,240)", ball_x, ball_y); else n_pass++;
      do_start(32'h0001_0001, 17'h0);
      n_total++; if (ball_x !== 10'd320 || ball_y !== 10'd240 || out_of_bounds !== 1'b0 || ball_stopped !== 1'b0) $display("FAIL oob_restart: got (%0d,%0d) oob %b stop %b want (320,240) 0 0", ball_x, ball_y, out_of_bounds, ball_stopped); else n_pass++;
   endtask

   task automatic test_reset_mid_req();
      bit h;
      do_reset();
      paddle_x = 0; paddle_y = 0;
      do_start(32'h0008_0006, 17'h0);
      paddle_x = 330; paddle_y = 245;
      do_step(0, h);
      rst_n = 0;
      @(negedge clk);
      n_total++; if (cif.Compute_collide !== 1'b0 || ball_x !== 10'd320 || cif.ball_velocity !== 32'h0) $display("FAIL rst_req: got req %b x=%0d vel %h want 0 320 0", cif.Compute_collide, ball_x, cif.ball_velocity); else n_pass++;
      rst_n = 1;
   endtask

   task automatic test_random();
      bit h, noise;
      int px, py, d;
      logic [31:0] nv;
      for (int s = 0; s < 8; s++) begin
         do_reset();
         paddle_x = 0; paddle_y = 0;
         do_start(rand_vel(), 17'($urandom));
         for (int i = 0; i < 30 && m_mode == M_MOVE; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               px = m_x + (m_sx ? -m_mx : m_mx) + int'($urandom_range(0, 20)) - 10;
               py = m_y + (m_sy ? -m_my : m_my) + int'($urandom_range(0, 20)) - 10;
            end else begin
               px = int'($urandom_range(0, 639));
               py = int'($urandom_range(0, 479));
            end
            paddle_x = 10'((px < 0) ? 0 : (px > 639) ? 639 : px);
            paddle_y = 10'((py < 0) ? 0 : (py > 479) ? 479 : py);
            noise = ($urandom_range(0, 3) == 0);
            do_step(noise, h);
            n_total++; if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || cif.ball_velocity !== m_vel()) $display("FAIL rnd_pos s%0d i%0d: got (%0d,%0d) %h want (%0d,%0d) %h", s, i, ball_x, ball_y, cif.ball_velocity, m_x, m_y, m_vel()); else n_pass++;
            n_total++; if (cif.Compute_collide !== h || out_of_bounds !== m_oob || ball_stopped !== (m_mode == M_STOP)) $display("FAIL rnd_flags s%0d i%0d: got req %b oob %b stop %b want %b %b %b", s, i, cif.Compute_collide, out_of_bounds, ball_stopped, h, m_oob, m_mode == M_STOP); else n_pass++;
            if (h) begin
               d = int'($urandom_range(0, 19));
               nv = rand_vel();
               do_break(d, nv, 17'($urandom));
               n_total++; if (cif.Compute_collide !== 1'b0 || ack_err !== m_aerr || ball_stopped !== (m_mode == M_STOP)) $display("FAIL rnd_ack s%0d d%0d: got req %b err %b stop %b want 0 %b %b", s, d, cif.Compute_collide, ack_err, ball_stopped, m_aerr, m_mode == M_STOP); else n_pass++;
               n_total++; if (cif.ball_velocity !== m_vel() || cif.ball_angle !== m_ang) $display("FAIL rnd_latch s%0d d%0d: got %h/%h want %h/%h", s, d, cif.ball_velocity, cif.ball_angle, m_vel(), m_ang); else n_pass++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_motion();
      test_wall();
      test_collision();
      test_stop();
      test_timeout();
      test_out_of_bounds();
      test_reset_mid_req();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
